// File: rtl/vram_arbiter.sv
// Arbitrates one asynchronous SRAM between a video read port and an MCU write port.
// Define VRAM_ARBITER_WRITE_FIFO_EN to post writes into a 4-entry FIFO instead of a single holding register.
module vram_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        videoReadRequest,
  input  logic [16:0] videoAddress,
  output logic [7:0]  videoReadData,
  output logic        videoReadComplete,
  input  logic        writeRequest,
  input  logic [16:0] writeAddress,
  input  logic [7:0]  writeData,
  output logic        writeComplete,
  output logic        writePending,
  output logic [16:0] ramAddress,
  output logic [7:0]  ramDataOut,
  input  logic [7:0]  ramDataIn,
  output logic        ramDataDrive,
  output logic        ramOutputEnableN,
  output logic        ramWriteEnableN
);

  typedef enum logic [2:0] {
    IDLE, READ_WAIT, READ_DONE, WRITE_SETUP, WRITE_PULSE, WRITE_HOLD
  } state_e;

  localparam logic [2:0] WAIT_LAST  = 3'(WAIT_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic [16:0] addr_q;
  logic [7:0]  data_q, rd_data_q;
  logic        rd_done_q, wr_done_q, wr_done_d;
  logic        grant_video, grant_write, wait_done, starved;
  logic        wr_avail;
  logic [16:0] wr_head_addr;
  logic [7:0]  wr_head_data;

`ifdef VRAM_ARBITER_WRITE_FIFO_EN
  logic [24:0] fifo_mem [4];
  logic [1:0]  fifo_rd_q, fifo_wr_q;
  logic [2:0]  fifo_cnt_q, fifo_cnt_d;
  logic        fifo_push;

  // The requester holds writeRequest through its own completion pulse; ignoring
  // it for that one cycle keeps a single request from being posted twice.
  assign fifo_push    = writeRequest && (fifo_cnt_q != 3'd4) && !wr_done_q;
  assign wr_avail     = (fifo_cnt_q != 3'd0);
  assign wr_head_addr = fifo_mem[fifo_rd_q][24:8];
  assign wr_head_data = fifo_mem[fifo_rd_q][7:0];
  assign wr_done_d    = fifo_push;
  assign writePending = wr_avail || ramDataDrive;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({fifo_push, grant_write})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push)   fifo_wr_q <= fifo_wr_q + 2'd1;
      if (grant_write) fifo_rd_q <= fifo_rd_q + 2'd1;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // NOTE: the storage array has no reset; clearing the pointers and count empties it.
  always_ff @(posedge clock) begin
    if (fifo_push) fifo_mem[fifo_wr_q] <= {writeAddress, writeData};
  end
`else
  logic run_q;

  // run_q keeps a request held across reset from showing as pending or being granted.
  assign wr_avail     = writeRequest && run_q;
  assign wr_head_addr = writeAddress;
  assign wr_head_data = writeData;
  assign wr_done_d    = (state_d == WRITE_HOLD);
  assign writePending = wr_avail;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) run_q <= 1'b0;
    else       run_q <= 1'b1;
  end
`endif

  assign wait_done = (wait_cnt_q == WAIT_LAST);
  assign starved   = wr_avail && (starve_q == STARVE_MAX);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      starve_q   <= starve_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    grant_video = 1'b0;
    grant_write = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (videoReadRequest && !starved) begin
          grant_video = 1'b1;
          wait_cnt_d  = '0;
          state_d     = READ_WAIT;
        end else if (wr_avail) begin
          grant_write = 1'b1;
          state_d     = WRITE_SETUP;
        end
      end
      READ_WAIT: begin
        if (wait_done) state_d = READ_DONE;
        else           wait_cnt_d = wait_cnt_q + 3'd1;
      end
      READ_DONE:   state_d = IDLE;
      WRITE_SETUP: begin
        wait_cnt_d = '0;
        state_d    = WRITE_PULSE;
      end
      WRITE_PULSE: begin
        if (wait_done) state_d = WRITE_HOLD;
        else           wait_cnt_d = wait_cnt_q + 3'd1;
      end
      WRITE_HOLD:  state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!wr_avail || grant_write) begin
      starve_d = '0;
    end else if (grant_video && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // SRAM strobes decode straight from the state flops, so reset idles the bus immediately.
  always_comb begin
    ramOutputEnableN = 1'b1;
    ramWriteEnableN  = 1'b1;
    ramDataDrive     = 1'b0;
    unique case (state_q)
      READ_WAIT, READ_DONE:    ramOutputEnableN = 1'b0;
      WRITE_SETUP, WRITE_HOLD: ramDataDrive = 1'b1;
      WRITE_PULSE: begin
        ramDataDrive    = 1'b1;
        ramWriteEnableN = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      data_q    <= '0;
      rd_data_q <= '0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      if (grant_video) addr_q <= videoAddress;
      if (grant_write) begin
        addr_q <= wr_head_addr;
        data_q <= wr_head_data;
      end
      if ((state_q == READ_WAIT) && wait_done) rd_data_q <= ramDataIn;
      rd_done_q <= (state_d == READ_DONE);
      wr_done_q <= wr_done_d;
    end
  end

  assign ramAddress        = addr_q;
  assign ramDataOut        = data_q;
  assign videoReadData     = rd_data_q;
  assign videoReadComplete = rd_done_q;
  assign writeComplete     = wr_done_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with default parameters (WAIT_CYCLES=1, STARVE_LIMIT=4).
// Build with VRAM_ARBITER_WRITE_FIFO_EN defined to exercise the posted-write variant.
module tb_vram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        videoReadRequest = 1'b0;
  logic [16:0] videoAddress = '0;
  logic [7:0]  videoReadData;
  logic        videoReadComplete;
  logic        writeRequest = 1'b0;
  logic [16:0] writeAddress = '0;
  logic [7:0]  writeData = '0;
  logic        writeComplete;
  logic        writePending;
  logic [16:0] ramAddress;
  logic [7:0]  ramDataOut;
  logic [7:0]  ramDataIn = '0;
  logic        ramDataDrive;
  logic        ramOutputEnableN;
  logic        ramWriteEnableN;

  int vectors     = 0;
  int miscompares = 0;
  int bus_viol    = 0;

  vram_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .videoReadRequest  (videoReadRequest),
    .videoAddress      (videoAddress),
    .videoReadData     (videoReadData),
    .videoReadComplete (videoReadComplete),
    .writeRequest      (writeRequest),
    .writeAddress      (writeAddress),
    .writeData         (writeData),
    .writeComplete     (writeComplete),
    .writePending      (writePending),
    .ramAddress        (ramAddress),
    .ramDataOut        (ramDataOut),
    .ramDataIn         (ramDataIn),
    .ramDataDrive      (ramDataDrive),
    .ramOutputEnableN  (ramOutputEnableN),
    .ramWriteEnableN   (ramWriteEnableN)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // SRAM bus must never see OE with WE, or OE while the data bus is driven.
  always @(negedge clock) begin
    if (!reset) begin
      if (!ramOutputEnableN && !ramWriteEnableN) bus_viol++;
      if (!ramOutputEnableN && ramDataDrive)     bus_viol++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary line");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) step();
    check("rst_oe_n",     32'(ramOutputEnableN),  32'd1);
    check("rst_we_n",     32'(ramWriteEnableN),   32'd1);
    check("rst_drive",    32'(ramDataDrive),      32'd0);
    check("rst_addr",     32'(ramAddress),        32'd0);
    check("rst_dout",     32'(ramDataOut),        32'd0);
    check("rst_rdata",    32'(videoReadData),     32'd0);
    check("rst_vcomp",    32'(videoReadComplete), 32'd0);
    check("rst_wcomp",    32'(writeComplete),     32'd0);
    check("rst_wpend",    32'(writePending),      32'd0);
    reset = 1'b0;
    repeat (2) step();

    // Single video read: OE low in READ_WAIT and READ_DONE, pulse two edges after the request.
    begin : read_test
      int oe_lo, done_at, pulses, addr_bad;
      oe_lo = 0; done_at = 0; pulses = 0; addr_bad = 0;
      videoAddress = 17'h00100;
      ramDataIn = 8'hA5;
      videoReadRequest = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        step();
        if (!ramOutputEnableN) begin
          oe_lo++;
          if (ramAddress !== 17'h00100) addr_bad++;
        end
        if (videoReadComplete) begin
          pulses++;
          if (done_at == 0) done_at = i;
          videoReadRequest = 1'b0;
          ramDataIn = 8'h00;
        end
      end
      check("rd_oe_cycles", oe_lo,    2);
      check("rd_done_step", done_at,  2);
      check("rd_pulses",    pulses,   1);
      check("rd_addr",      addr_bad, 0);
      check("rd_data",      32'(videoReadData), 32'h0000_00A5);
    end

`ifdef VRAM_ARBITER_WRITE_FIFO_EN
    // Six posted writes against saturating video: four fit, the fifth waits for the first drain.
    begin : fifo_test
      logic [16:0] got_addr [6];
      logic [7:0]  got_data [6];
      int acc, acc_at_drain, drained, timeouts, pend_at_last;
      bit seen_drive, prev_we_n;
      acc = 0; acc_at_drain = -1; drained = 0; timeouts = 0; pend_at_last = 0;
      seen_drive = 1'b0; prev_we_n = 1'b1;
      videoAddress = 17'h00300;
      ramDataIn = 8'h22;
      videoReadRequest = 1'b1;
      fork
        begin
          for (int w = 0; w < 6; w++) begin
            bit got;
            got = 1'b0;
            writeAddress = 17'h10000 + 17'(w);
            writeData    = 8'hC0 + 8'(w);
            writeRequest = 1'b1;
            for (int c = 0; c < 300 && !got; c++) begin
              step();
              if (writeComplete) got = 1'b1;
            end
            writeRequest = 1'b0;
            if (!got) timeouts++;
            step();
          end
        end
        begin
          for (int c = 0; c < 600 && drained < 6; c++) begin
            step();
            if (ramDataDrive && !seen_drive) begin
              seen_drive = 1'b1;
              acc_at_drain = acc;
            end
            if (writeComplete) acc++;
            if (!ramWriteEnableN && prev_we_n) begin
              got_addr[drained] = ramAddress;
              got_data[drained] = ramDataOut;
              if (drained == 5) pend_at_last = 32'(writePending);
              drained++;
            end
            prev_we_n = ramWriteEnableN;
          end
        end
      join
      check("fifo_acc_before_drain", acc_at_drain, 4);
      check("fifo_accept_timeouts",  timeouts,     0);
      check("fifo_drained",          drained,      6);
      for (int k = 0; k < 6; k++) begin
        check($sformatf("fifo_addr%0d", k), 32'(got_addr[k]), 32'h10000 + k);
        check($sformatf("fifo_data%0d", k), 32'(got_data[k]), 32'hC0 + k);
      end
      check("fifo_pend_at_last", pend_at_last, 1);
      videoReadRequest = 1'b0;
      repeat (6) step();
      check("fifo_pend_after", 32'(writePending), 32'd0);
    end
`else
    // Lone write: setup/pulse/hold of one cycle each, complete during hold.
    begin : write_test
      int drv_we_hi, we_lo, bad, done_at, pulses, pend_bad;
      drv_we_hi = 0; we_lo = 0; bad = 0; done_at = 0; pulses = 0; pend_bad = 0;
      writeAddress = 17'h1FFFF;
      writeData = 8'h3C;
      writeRequest = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        step();
        if (ramDataDrive && ramWriteEnableN) drv_we_hi++;
        if (!ramWriteEnableN) we_lo++;
        if (ramDataDrive && (ramDataOut !== 8'h3C || ramAddress !== 17'h1FFFF)) bad++;
        if (writeRequest && !writePending) pend_bad++;
        if (writeComplete) begin
          pulses++;
          if (done_at == 0) done_at = i;
          writeRequest = 1'b0;
        end
      end
      check("wr_setup_hold_cycles", drv_we_hi, 2);
      check("wr_we_low_cycles",     we_lo,     1);
      check("wr_bus_values",        bad,       0);
      check("wr_done_step",         done_at,   3);
      check("wr_pulses",            pulses,    1);
      check("wr_pending_while_req", pend_bad,  0);
      check("wr_pending_after",     32'(writePending), 32'd0);
    end

    // Continuous video plus one write: four reads, the write, then video resumes.
    begin : starve_test
      int vcnt, wcnt, resumed;
      bit wdone;
      vcnt = 0; wcnt = 0; resumed = 0; wdone = 1'b0;
      videoAddress = 17'h00200;
      ramDataIn = 8'h11;
      writeAddress = 17'h00040;
      writeData = 8'h77;
      videoReadRequest = 1'b1;
      writeRequest = 1'b1;
      for (int i = 1; i <= 40; i++) begin
        step();
        if (videoReadComplete) begin
          if (!wdone) vcnt++;
          else if (resumed == 0) begin
            resumed = 1;
            videoReadRequest = 1'b0;
          end
        end
        if (writeComplete) begin
          wcnt++;
          wdone = 1'b1;
          writeRequest = 1'b0;
        end
      end
      check("starve_reads_before_write", vcnt,    4);
      check("starve_write_pulses",       wcnt,    1);
      check("starve_video_resumed",      resumed, 1);
    end

    // Simultaneous arrival with a clear starvation count: video first, write next.
    begin : simul_test
      int vcnt, wcnt, v_at, w_at;
      vcnt = 0; wcnt = 0; v_at = 0; w_at = 0;
      videoAddress = 17'h00010;
      writeAddress = 17'h00020;
      writeData = 8'h5C;
      videoReadRequest = 1'b1;
      writeRequest = 1'b1;
      for (int i = 1; i <= 15; i++) begin
        step();
        if (videoReadComplete) begin
          vcnt++;
          v_at = i;
          videoReadRequest = 1'b0;
        end
        if (writeComplete) begin
          wcnt++;
          w_at = i;
          writeRequest = 1'b0;
        end
      end
      check("simul_video_step",   v_at, 2);
      check("simul_write_step",   w_at, 6);
      check("simul_video_pulses", vcnt, 1);
      check("simul_write_pulses", wcnt, 1);
    end

    // Reset during WRITE_PULSE: bus idles at once and the write never completes.
    begin : reset_test
      int wcnt, we_lo;
      wcnt = 0; we_lo = 0;
      writeAddress = 17'h0ABCD;
      writeData = 8'h5A;
      writeRequest = 1'b1;
      step();
      step();
      check("rstw_in_pulse", 32'(ramWriteEnableN), 32'd0);
      writeRequest = 1'b0;
      reset = 1'b1;
      #1;
      check("rstw_we_n",  32'(ramWriteEnableN),  32'd1);
      check("rstw_drive", 32'(ramDataDrive),     32'd0);
      check("rstw_oe_n",  32'(ramOutputEnableN), 32'd1);
      check("rstw_pend",  32'(writePending),     32'd0);
      check("rstw_addr",  32'(ramAddress),       32'd0);
      check("rstw_dout",  32'(ramDataOut),       32'd0);
      check("rstw_rdata", 32'(videoReadData),    32'd0);
      step();
      reset = 1'b0;
      for (int i = 1; i <= 10; i++) begin
        step();
        if (writeComplete) wcnt++;
        if (!ramWriteEnableN) we_lo++;
      end
      check("rstw_no_complete", wcnt, 0);
      check("rstw_no_we",       we_lo, 0);
      check("rstw_pend_after",  32'(writePending), 32'd0);
    end
`endif

    check("bus_exclusive", bus_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
